// File: rtl/tx_f36_scheduler_pkg.sv
// Shared definitions for the tx_f36 packet scheduler.
// Holds the f36 flag bit positions, the source/grant codes, the framing FSM
// state encoding and the header field layout. It also holds a helper that
// assembles the one-word packet header.
package tx_f36_scheduler_pkg;

  // f36 flag bit positions
  localparam int FLAG_SOF     = 0;
  localparam int FLAG_EOF     = 1;
  localparam int FLAG_OCC_LSB = 2;
  localparam int FLAG_OCC_MSB = 3;

  // Source codes. The same encoding drives the grant port and the header
  // grant field.
  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_PRI  = 2'b01,
    SRC_SEC  = 2'b10
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_GAP
  } state_e;

  // Header word layout: [31:30] grant, [29:26] zero, [25:16] len, [15:0] seq
  localparam int HDR_GRANT_LSB = 30;
  localparam int HDR_LEN_LSB   = 16;
  localparam int HDR_LEN_W     = 10;
  localparam int HDR_SEQ_LSB   = 0;
  localparam int HDR_SEQ_W     = 16;

  function automatic logic [31:0] make_header(input src_e                  src,
                                              input logic [HDR_LEN_W-1:0] len,
                                              input logic [HDR_SEQ_W-1:0] seq);
    logic [31:0] h;
    h = '0;
    h[HDR_GRANT_LSB +: 2]       = src;
    h[HDR_LEN_LSB +: HDR_LEN_W] = len;
    h[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
    return h;
  endfunction

endpackage

// File: rtl/tx_f36_scheduler_arbiter.sv
// tx_grant_arbiter: chooses the packet source during the IDLE arbitration cycle.
// By default the primary source wins. The secondary source is forced to win
// once it has waited through STARVE_LIMIT consecutive primary grants.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   arb_en      - high in the IDLE cycle, when a grant may be issued
//   pri_req     - request from the primary source
//   sec_req     - request from the secondary source
//   grant_sel   - source granted this cycle (SRC_NONE when no grant)
module tx_grant_arbiter
  import tx_f36_scheduler_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic pri_req,
  input  logic sec_req,
  output src_e grant_sel
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_sel = SRC_NONE;
    if (arb_en) begin
      if (pri_req && sec_req) grant_sel = (starve_q == LIMIT) ? SRC_SEC : SRC_PRI;
      else if (pri_req)       grant_sel = SRC_PRI;
      else if (sec_req)       grant_sel = SRC_SEC;
    end
  end

  // Count primary wins that happened while the secondary source was waiting.
  always_comb begin
    starve_d = starve_q;
    if (grant_sel == SRC_SEC)
      starve_d = '0;
    else if (grant_sel == SRC_PRI && sec_req && starve_q != LIMIT)
      starve_d = starve_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled on the clock edge (synchronous).
  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

endmodule

// File: rtl/tx_f36_scheduler.sv
// tx_f36_scheduler: frames packets from two FWFT FIFOs onto the tx_f36 port.
// One source is granted per packet. The scheduler sends a one-word header and
// then exactly len payload words, passed through from the granted FIFO. It
// then inserts GAP_CYCLES idle cycles before the next arbitration.
// Ports:
//   clk, reset                 - dsp_clk and synchronous active-high reset
//   pri_req/pri_size/pri_d     - primary FIFO: ready flag, length, FWFT data
//   pri_rd                     - primary FIFO pop
//   sec_req/sec_size/sec_d     - secondary FIFO: ready flag, length, FWFT data
//   sec_rd                     - secondary FIFO pop
//   wr_data_o/wr_flags_o       - f36 data and flags (SOF, EOF, occupancy=00)
//   wr_src_rdy_o/wr_dst_rdy_i  - f36 handshake
//   grant                      - active source (01 pri, 10 sec, 00 none)
//   busy                       - high in any state other than IDLE
module tx_f36_scheduler
  import tx_f36_scheduler_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int SIZE_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pri_req,
  input  logic [SIZE_W-1:0] pri_size,
  input  logic [31:0]       pri_d,
  output logic              pri_rd,
  input  logic              sec_req,
  input  logic [SIZE_W-1:0] sec_size,
  input  logic [31:0]       sec_d,
  output logic              sec_rd,
  output logic [31:0]       wr_data_o,
  output logic [3:0]        wr_flags_o,
  output logic              wr_src_rdy_o,
  input  logic              wr_dst_rdy_i,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int GAP_W = 4;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  src_e              grant_q, grant_d;
  logic [SIZE_W-1:0] len_q, len_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [15:0]       seq_pri_q, seq_pri_d;
  logic [15:0]       seq_sec_q, seq_sec_d;

  src_e arb_grant;
  logic xfer;
  logic last_word;

  tx_grant_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .arb_en    (state_q == ST_IDLE),
    .pri_req   (pri_req),
    .sec_req   (sec_req),
    .grant_sel (arb_grant)
  );

  // The f36 side only presents words in HDR and PAYLOAD. A transfer is
  // therefore those states with the sink ready. While the sink is not ready,
  // every counter holds.
  assign xfer      = (state_q == ST_HDR || state_q == ST_PAYLOAD) && wr_dst_rdy_i;
  assign last_word = (cnt_q == len_q);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= SRC_NONE;
      len_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      seq_pri_q <= '0;
      seq_sec_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      seq_pri_q <= seq_pri_d;
      seq_sec_q <= seq_sec_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    seq_pri_d = seq_pri_q;
    seq_sec_d = seq_sec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_grant != SRC_NONE) begin
          grant_d = arb_grant;
          len_d   = (arb_grant == SRC_PRI) ? pri_size : sec_size;
          cnt_d   = SIZE_W'(1);
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          if (grant_q == SRC_PRI) seq_pri_d = seq_pri_q + 16'd1;
          else                    seq_sec_d = seq_sec_q + 16'd1;
          gap_d   = '0;
          state_d = (len_q == '0) ? ST_GAP : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          if (last_word) begin
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          grant_d = SRC_NONE;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    wr_data_o    = '0;
    wr_flags_o   = '0;
    wr_src_rdy_o = 1'b0;
    pri_rd       = 1'b0;
    sec_rd       = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        wr_src_rdy_o         = 1'b1;
        wr_data_o            = make_header(grant_q, HDR_LEN_W'(len_q),
                                           (grant_q == SRC_PRI) ? seq_pri_q : seq_sec_q);
        wr_flags_o[FLAG_SOF] = 1'b1;
        wr_flags_o[FLAG_EOF] = (len_q == '0);
      end
      ST_PAYLOAD: begin
        // The FWFT head goes straight through, and the pop follows the sink's
        // ready, so the FIFO advances only on an accepted word.
        wr_src_rdy_o         = 1'b1;
        wr_data_o            = (grant_q == SRC_SEC) ? sec_d : pri_d;
        wr_flags_o[FLAG_EOF] = last_word;
        pri_rd               = (grant_q == SRC_PRI) && wr_dst_rdy_i;
        sec_rd               = (grant_q == SRC_SEC) && wr_dst_rdy_i;
      end
      default: ;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
